seq_alu: RTL and testbench
==========================

// Module: seq_alu
// PURPOSE
//  Parametrised multi-cycle ALU; successor to the single-cycle combinational ALU.
//  Keeps the existing ALUcontrol encodings and adds XOR, shifts, unsigned multiply
//  and unsigned divide/remainder (RV32M-style) with a valid/ready handshake.
//  Sits between decode and writeback in the multi-cycle core. Stalls the core
//  while a MUL/DIV iterates.
// PARAMETERS
//  WIDTH   32  operand/result width; power of two, >= 8
//  (local) SH_W = $clog2(WIDTH): shift-amount width; CNT_W = $clog2(WIDTH)+1
// PORTS
//  clk         in   1      single clock; all state on rising edge
//  reset       in   1      asynchronous, active-high reset
//  in_valid    in   1      operands/op valid
//  in_ready    out  1      block can accept an op (high only in IDLE)
//  ALUcontrol  in   4      operation code, captured on accept
//  A           in   WIDTH  operand A, captured on accept
//  B           in   WIDTH  operand B, captured on accept
//  out_valid   out  1      ALUResult/isZero valid (high only in DONE)
//  out_ready   in   1      consumer takes result
//  ALUResult   out  WIDTH  registered result
//  isZero      out  1      registered (ALUResult == 0)
//  div_by_zero out  1      registered; set with result of DIVU/REMU when B == 0
// BEHAVIOUR
//  Clock/reset: one clock; reset asynchronous, active-high. On reset: state=IDLE,
//   in_ready=1, out_valid=0, ALUResult=0, isZero=1, div_by_zero=0, counter=0.
//  Reset mid-operation aborts the op; no result is produced.
//  Accept = in_valid & in_ready. No pipelining: one op in flight.
//  Ops (unsigned unless noted): 0 AND, 1 OR, 2 ADD (wraps mod 2^WIDTH), 3 XOR,
//   4 SLL by B[SH_W-1:0], 5 SRL by B[SH_W-1:0], 6 SUB (wraps), 7 SLTU -> 1/0,
//   8 MUL low WIDTH bits, 9 MULHU high WIDTH bits, 10 DIVU quotient,
//   11 REMU remainder, 12 NOR, 13-15 -> result 0.
//  FSM IDLE/CALC/DONE:
//   IDLE: on accept of single-cycle op (0-7,12-15) compute, register result -> DONE.
//    On accept of 8-11 with B!=0 or op 8/9: load operands, counter=WIDTH -> CALC.
//    DIVU/REMU with B==0: result = all-ones (DIVU) or A (REMU), div_by_zero=1 -> DONE.
//   CALC: one iteration per cycle. MUL: shift-add over 2*WIDTH product reg.
//    DIV: restoring, 1 quotient bit per cycle. counter decrements; when counter==1
//    the final iteration completes and result registers -> DONE.
//   DONE: out_valid=1, outputs held stable until out_ready; on out_ready -> IDLE.
//    in_ready not asserted in the same cycle as out_ready (accept next cycle).
//  Latency (accept edge = cycle 0): single-cycle ops and div-by-zero: out_valid
//   in cycle 1. MUL/MULHU/DIVU/REMU: out_valid in cycle WIDTH+1.
//  Throughput: single-cycle op every 2 cycles with out_ready held high.
//  isZero and div_by_zero update only when ALUResult updates; div_by_zero cleared
//   on any other result. in_valid while busy is ignored (not captured).
//  A/B/ALUcontrol changing after accept have no effect on the in-flight op.
// TESTING
//  1 Reset asserted mid-CALC of MUL -> next cycle state IDLE, in_ready=1,
//    out_valid=0, ALUResult=0, isZero=1; no stale result appears later.
//  2 ADD A=32'hFFFF_FFFF B=1 -> cycle 1 out_valid=1, ALUResult=0, isZero=1;
//    SLTU A=3 B=5 -> 1; NOR A=0 B=0 -> 32'hFFFF_FFFF; SLL A=1 B=33 -> 2.
//  3 MUL A=32'h0001_0000 B=32'h0001_0000 -> out_valid at cycle 33, ALUResult=0,
//    isZero=1; MULHU same operands -> 1; MUL 7*6 -> 42.
//  4 DIVU A=100 B=7 -> cycle 33 result 14; REMU -> 2; DIVU A=5 B=0 -> cycle 1
//    result 32'hFFFF_FFFF, div_by_zero=1; REMU A=5 B=0 -> 5, div_by_zero=1.
//  5 Backpressure: out_ready=0 for 10 cycles after DONE -> outputs stable,
//    in_ready=0, new in_valid ignored; out_ready=1 -> IDLE next cycle.
//  6 WIDTH=8: MULHU 8'hFF*8'hFF -> 8'hFE at cycle 9; SRL A=8'h80 B=7 -> 1.

Source files
------------

// File: rtl/seq_alu_if.sv
// Operand/result handshake bundle for seq_alu.
// master = issuing stage (decode side), slave = the ALU.
interface seq_alu_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       ALUcontrol;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] ALUResult;
   logic             isZero;
   logic             div_by_zero;

   modport master (
      output in_valid, ALUcontrol, A, B, out_ready,
      input  in_ready, out_valid, ALUResult, isZero, div_by_zero
   );

   modport slave (
      input  in_valid, ALUcontrol, A, B, out_ready,
      output in_ready, out_valid, ALUResult, isZero, div_by_zero
   );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle logic/arith ops plus iterative unsigned
// MUL/MULHU (shift-add) and DIVU/REMU (restoring), one op in flight.
module seq_alu #(
   parameter int WIDTH = 32
) (
   input  logic     clk,
   input  logic     reset,
   seq_alu_if.slave bus
);
   localparam int SH_W  = $clog2(WIDTH);
   localparam int CNT_W = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

   typedef enum logic [3:0] {
      OP_AND   = 4'd0,  OP_OR    = 4'd1,  OP_ADD  = 4'd2,  OP_XOR  = 4'd3,
      OP_SLL   = 4'd4,  OP_SRL   = 4'd5,  OP_SUB  = 4'd6,  OP_SLTU = 4'd7,
      OP_MUL   = 4'd8,  OP_MULHU = 4'd9,  OP_DIVU = 4'd10, OP_REMU = 4'd11,
      OP_NOR   = 4'd12
   } op_e;

   state_e               r_state, w_state_nxt;
   logic [3:0]           r_op;
   logic [WIDTH-1:0]     r_b;
   logic [2*WIDTH-1:0]   r_prod, w_prod_nxt;
   logic [CNT_W-1:0]     r_cnt;
   logic [WIDTH-1:0]     r_result;
   logic                 r_zero, r_dbz;
   logic [WIDTH-1:0]     w_alu_res, w_iter_res;
   logic                 w_accept, w_div_op, w_multi, w_bzero, w_to_calc, w_r_div, w_last;
   logic [WIDTH:0]       w_mul_sum, w_div_tmp, w_div_diff;

   assign w_accept  = bus.in_valid && (r_state == S_IDLE);
   assign w_div_op  = (bus.ALUcontrol == OP_DIVU) || (bus.ALUcontrol == OP_REMU);
   assign w_multi   = w_div_op || (bus.ALUcontrol == OP_MUL) || (bus.ALUcontrol == OP_MULHU);
   assign w_bzero   = (bus.B == '0);
   assign w_to_calc = w_multi && !(w_div_op && w_bzero);
   assign w_r_div   = (r_op == OP_DIVU) || (r_op == OP_REMU);
   assign w_last    = (r_cnt == CNT_W'(1));

   // DIVU/REMU entries here only matter for the divide-by-zero shortcut
   always_comb begin
      w_alu_res = '0;
      case (bus.ALUcontrol)
         OP_AND:  w_alu_res = bus.A & bus.B;
         OP_OR:   w_alu_res = bus.A | bus.B;
         OP_ADD:  w_alu_res = bus.A + bus.B;
         OP_XOR:  w_alu_res = bus.A ^ bus.B;
         OP_SLL:  w_alu_res = bus.A << bus.B[SH_W-1:0];
         OP_SRL:  w_alu_res = bus.A >> bus.B[SH_W-1:0];
         OP_SUB:  w_alu_res = bus.A - bus.B;
         OP_SLTU: w_alu_res = {{(WIDTH-1){1'b0}}, (bus.A < bus.B)};
         OP_DIVU: w_alu_res = '1;
         OP_REMU: w_alu_res = bus.A;
         OP_NOR:  w_alu_res = ~(bus.A | bus.B);
         default: w_alu_res = '0;
      endcase
   end

   // r_prod holds {acc, multiplier} for MUL and {remainder, dividend/quotient} for DIV
   always_comb begin
      w_mul_sum  = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_b} : '0);
      w_div_tmp  = r_prod[2*WIDTH-1:WIDTH-1];
      w_div_diff = w_div_tmp - {1'b0, r_b};
      if (w_r_div) begin
         if (!w_div_diff[WIDTH])
            w_prod_nxt = {w_div_diff[WIDTH-1:0], r_prod[WIDTH-2:0], 1'b1};
         else
            w_prod_nxt = {w_div_tmp[WIDTH-1:0], r_prod[WIDTH-2:0], 1'b0};
      end else begin
         w_prod_nxt = {w_mul_sum, r_prod[WIDTH-1:1]};
      end
      if ((r_op == OP_MUL) || (r_op == OP_DIVU))
         w_iter_res = w_prod_nxt[WIDTH-1:0];
      else
         w_iter_res = w_prod_nxt[2*WIDTH-1:WIDTH];
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_state_nxt = w_to_calc ? S_CALC : S_DONE;
         S_CALC:  if (w_last) w_state_nxt = S_DONE;
         S_DONE:  if (bus.out_ready) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_op     <= '0;
         r_b      <= '0;
         r_prod   <= '0;
         r_cnt    <= '0;
         r_result <= '0;
         r_zero   <= 1'b1;
         r_dbz    <= 1'b0;
      end else if (w_accept) begin
         r_op   <= bus.ALUcontrol;
         r_b    <= bus.B;
         r_prod <= {{WIDTH{1'b0}}, bus.A};
         if (w_to_calc) begin
            r_cnt <= CNT_W'(WIDTH);
         end else begin
            r_result <= w_alu_res;
            r_zero   <= (w_alu_res == '0);
            r_dbz    <= w_div_op && w_bzero;
         end
      end else if (r_state == S_CALC) begin
         r_prod <= w_prod_nxt;
         r_cnt  <= r_cnt - CNT_W'(1);
         if (w_last) begin
            r_result <= w_iter_res;
            r_zero   <= (w_iter_res == '0);
            r_dbz    <= 1'b0;
         end
      end
   end

   assign bus.in_ready    = (r_state == S_IDLE);
   assign bus.out_valid   = (r_state == S_DONE);
   assign bus.ALUResult   = r_result;
   assign bus.isZero      = r_zero;
   assign bus.div_by_zero = r_dbz;
endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: directed ops on a 32-bit and an 8-bit instance,
// with expected results queued at issue and checked by a separate monitor.
module tb_seq_alu;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst32, rst8;
   seq_alu_if #(.WIDTH(32)) bus32();
   seq_alu_if #(.WIDTH(8))  bus8();

   seq_alu #(.WIDTH(32)) u_dut32 (.clk(clk), .reset(rst32), .bus(bus32));
   seq_alu #(.WIDTH(8))  u_dut8  (.clk(clk), .reset(rst8),  .bus(bus8));

   typedef struct {
      logic [31:0] res;
      logic        dbz;
      int          lat;
      int          acc;
   } exp_t;

   exp_t q32[$];
   exp_t q8[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc   = 0;
   bit   done  = 1'b0;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   task automatic fail_now(input string nm);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: bound expired or unexpected event (cycle %0d)", nm, cyc);
   endtask

   task automatic compare(input string tag, input exp_t e, input logic [31:0] res,
                          input logic zf, input logic dbz);
      check({tag, "_result"}, res, e.res);
      check({tag, "_isZero"}, {31'b0, zf}, {31'b0, (e.res == 32'd0)});
      check({tag, "_div_by_zero"}, {31'b0, dbz}, {31'b0, e.dbz});
      check({tag, "_latency"}, cyc - e.acc + 1, e.lat);
   endtask

   // Monitor: pops one entry on each fresh out_valid of each instance
   initial begin
      bit   seen32 = 1'b0;
      bit   seen8  = 1'b0;
      exp_t e;
      while (!done) begin
         @(negedge clk);
         if (bus32.out_valid && !seen32) begin
            seen32 = 1'b1;
            if (q32.size() == 0) fail_now("unexpected_out32");
            else begin
               e = q32.pop_front();
               compare("w32", e, bus32.ALUResult, bus32.isZero, bus32.div_by_zero);
            end
         end else if (!bus32.out_valid) seen32 = 1'b0;
         if (bus8.out_valid && !seen8) begin
            seen8 = 1'b1;
            if (q8.size() == 0) fail_now("unexpected_out8");
            else begin
               e = q8.pop_front();
               compare("w8", e, {24'b0, bus8.ALUResult}, bus8.isZero, bus8.div_by_zero);
            end
         end else if (!bus8.out_valid) seen8 = 1'b0;
      end
   end

   // Called at a negedge; returns at the negedge after the accept edge
   task automatic issue(input int sel, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] res, input logic dbz,
                        input int lat, input bit push = 1'b1);
      int   t = 0;
      exp_t e;
      while (((sel == 32) ? !bus32.in_ready : !bus8.in_ready) && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (t >= 300) begin
         fail_now("in_ready_wait");
         return;
      end
      if (sel == 32) begin
         bus32.in_valid = 1'b1; bus32.ALUcontrol = op; bus32.A = a; bus32.B = b;
      end else begin
         bus8.in_valid = 1'b1; bus8.ALUcontrol = op; bus8.A = a[7:0]; bus8.B = b[7:0];
      end
      e.res = res; e.dbz = dbz; e.lat = lat; e.acc = cyc + 1;
      if (push) begin
         if (sel == 32) q32.push_back(e);
         else           q8.push_back(e);
      end
      @(negedge clk);
      // Operands change after accept; the in-flight op must not see them
      if (sel == 32) begin
         bus32.in_valid = 1'b0; bus32.A = $urandom; bus32.B = $urandom;
         bus32.ALUcontrol = 4'($urandom);
      end else begin
         bus8.in_valid = 1'b0; bus8.A = 8'($urandom); bus8.B = 8'($urandom);
         bus8.ALUcontrol = 4'($urandom);
      end
   endtask

   task automatic drain();
      int t = 0;
      while ((q32.size() != 0 || q8.size() != 0) && t < 500) begin
         @(negedge clk);
         t++;
      end
      if (t >= 500) fail_now("drain");
      @(negedge clk);
   endtask

   initial begin
      rst32 = 1'b1; rst8 = 1'b1;
      bus32.in_valid = 1'b0; bus32.out_ready = 1'b1; bus32.ALUcontrol = '0;
      bus32.A = '0; bus32.B = '0;
      bus8.in_valid = 1'b0; bus8.out_ready = 1'b1; bus8.ALUcontrol = '0;
      bus8.A = '0; bus8.B = '0;
      repeat (2) @(negedge clk);
      check("rst_in_ready", {31'b0, bus32.in_ready}, 32'd1);
      check("rst_out_valid", {31'b0, bus32.out_valid}, 32'd0);
      check("rst_result", bus32.ALUResult, 32'd0);
      check("rst_isZero", {31'b0, bus32.isZero}, 32'd1);
      check("rst_dbz", {31'b0, bus32.div_by_zero}, 32'd0);
      check("rst8_result", {24'b0, bus8.ALUResult}, 32'd0);
      rst32 = 1'b0; rst8 = 1'b0;
      @(negedge clk);

      // Single-cycle ops
      issue(32, 4'd2,  32'hFFFF_FFFF, 32'd1,        32'd0,        1'b0, 1);
      issue(32, 4'd7,  32'd3,         32'd5,        32'd1,        1'b0, 1);
      issue(32, 4'd7,  32'd5,         32'd3,        32'd0,        1'b0, 1);
      issue(32, 4'd12, 32'd0,         32'd0,        32'hFFFF_FFFF, 1'b0, 1);
      issue(32, 4'd4,  32'd1,         32'd33,       32'd2,        1'b0, 1);
      issue(32, 4'd5,  32'h8000_0000, 32'd31,       32'd1,        1'b0, 1);
      issue(32, 4'd6,  32'd0,         32'd1,        32'hFFFF_FFFF, 1'b0, 1);
      issue(32, 4'd3,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 1);
      issue(32, 4'd0,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1);
      issue(32, 4'd1,  32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, 1'b0, 1);
      issue(32, 4'd13, 32'h1234_5678, 32'h1,        32'd0,        1'b0, 1);
      drain();

      // Iterative multiply / divide
      issue(32, 4'd8,  32'h0001_0000, 32'h0001_0000, 32'd0,  1'b0, 33);
      issue(32, 4'd9,  32'h0001_0000, 32'h0001_0000, 32'd1,  1'b0, 33);
      issue(32, 4'd8,  32'd7,         32'd6,         32'd42, 1'b0, 33);
      issue(32, 4'd10, 32'd100,       32'd7,         32'd14, 1'b0, 33);
      issue(32, 4'd11, 32'd100,       32'd7,         32'd2,  1'b0, 33);
      issue(32, 4'd10, 32'd5,         32'd0,         32'hFFFF_FFFF, 1'b1, 1);
      issue(32, 4'd11, 32'd5,         32'd0,         32'd5,  1'b1, 1);
      issue(32, 4'd2,  32'd1,         32'd1,         32'd2,  1'b0, 1);
      drain();

      // Backpressure: hold DONE for 10 cycles while a new op is offered
      bus32.out_ready = 1'b0;
      issue(32, 4'd3, 32'h0000_00FF, 32'h0000_0F0F, 32'h0000_0FF0, 1'b0, 1);
      bus32.in_valid = 1'b1; bus32.ALUcontrol = 4'd2; bus32.A = 32'd9; bus32.B = 32'd9;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("bp_result", bus32.ALUResult, 32'h0000_0FF0);
         check("bp_out_valid", {31'b0, bus32.out_valid}, 32'd1);
         check("bp_in_ready", {31'b0, bus32.in_ready}, 32'd0);
      end
      bus32.in_valid = 1'b0; bus32.out_ready = 1'b1;
      @(negedge clk);
      check("bp_release_in_ready", {31'b0, bus32.in_ready}, 32'd1);
      check("bp_release_out_valid", {31'b0, bus32.out_valid}, 32'd0);
      drain();

      // Reset in the middle of a MUL: nothing may come out afterwards
      issue(32, 4'd8, 32'd123, 32'd456, 32'd0, 1'b0, 33, 1'b0);
      repeat (5) @(negedge clk);
      rst32 = 1'b1;
      #1;
      check("midrst_in_ready", {31'b0, bus32.in_ready}, 32'd1);
      check("midrst_out_valid", {31'b0, bus32.out_valid}, 32'd0);
      check("midrst_result", bus32.ALUResult, 32'd0);
      check("midrst_isZero", {31'b0, bus32.isZero}, 32'd1);
      @(negedge clk);
      rst32 = 1'b0;
      repeat (40) @(negedge clk);
      check("midrst_idle_out_valid", {31'b0, bus32.out_valid}, 32'd0);
      issue(32, 4'd8, 32'd3, 32'd5, 32'd15, 1'b0, 33);
      drain();

      // 8-bit instance
      issue(8, 4'd9,  32'hFF, 32'hFF, 32'hFE, 1'b0, 9);
      issue(8, 4'd8,  32'hFF, 32'hFF, 32'h01, 1'b0, 9);
      issue(8, 4'd5,  32'h80, 32'd7,  32'h01, 1'b0, 1);
      issue(8, 4'd10, 32'd200, 32'd9, 32'd22, 1'b0, 9);
      issue(8, 4'd11, 32'd200, 32'd9, 32'd2,  1'b0, 9);
      issue(8, 4'd2,  32'hFF, 32'h01, 32'h00, 1'b0, 1);
      drain();

      done = 1'b1;
      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
